// File: rtl/lz_normalizer.sv
// Left-justifies a data word using its supplied leading-zero count and reports
// the original MSB position. Two-stage valid/ready pipeline with backpressure.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  input handshake; in_ready depends combinationally on out_ready
//   in_data, in_cnt    raw word and its leading-zero count
//   out_valid/out_ready output handshake
//   out_data           in_data << saturated in_cnt
//   out_msb_pos        DATA_WIDTH-1-cnt, 0 for a zero word
//   out_zero           count says the word is zero (cnt >= DATA_WIDTH)
//   out_err            count inconsistent with the data
module lz_normalizer #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CNT_WIDTH-1:0]  in_cnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_msb_pos,
  output logic                  out_zero,
  output logic                  out_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] POS_TOP = CNT_WIDTH'(DATA_WIDTH - 1);

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [CNT_WIDTH-1:0]  s1_cnt;
  logic                  s2_valid;

  logic                  s2_take;
  logic                  s1_take;
  logic [CNT_WIDTH-1:0]  cnt_sat;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  s1_zero;
  logic [CNT_WIDTH-1:0]  msb_pos;
  logic                  err;

  // Pipeline advance: a stage may load when it is empty or its contents move on.
  always_comb begin
    s2_take = !s2_valid || out_ready;
    s1_take = !s1_valid || s2_take;
  end

  assign in_ready  = s1_take;
  assign out_valid = s2_valid;

  // Stage-2 arithmetic from stage-1 registers.
  always_comb begin
    cnt_sat = (in_cnt > CNT_MAX) ? CNT_MAX : in_cnt;
    shifted = s1_data << s1_cnt;
    s1_zero = (s1_cnt == CNT_MAX);
    msb_pos = s1_zero ? '0 : (POS_TOP - s1_cnt);
    // The bit the count claims is the MSB lands in shifted[DATA_WIDTH-1].
    err     = (s1_data != '0) && (s1_zero || !shifted[DATA_WIDTH-1]);
  end

  // Pipeline registers; output fields only load with a valid word so they hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_cnt      <= '0;
      s2_valid    <= 1'b0;
      out_data    <= '0;
      out_msb_pos <= '0;
      out_zero    <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      if (s1_take) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_cnt  <= cnt_sat;
        end
      end
      if (s2_take) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data    <= shifted;
          out_msb_pos <= msb_pos;
          out_zero    <= s1_zero;
          out_err     <= err;
        end
      end
    end
  end

endmodule

// File: tb/tb_lz_normalizer.sv
// Self-checking bench for lz_normalizer: reference model plus in-order scoreboard.
module tb_lz_normalizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic [3:0] in_cnt;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [3:0] out_msb_pos;
  logic       out_zero;
  logic       out_err;

  lz_normalizer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_cnt      (in_cnt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_msb_pos (out_msb_pos),
    .out_zero    (out_zero),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] d;
    logic [3:0] m;
    logic       z;
    logic       e;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_acc = 0;
  bit   lat_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected result from the arithmetic definition of normalisation.
  function automatic exp_t model(input logic [9:0] d, input logic [3:0] c);
    exp_t r;
    int   s;
    int   dv;
    dv  = int'(d);
    s   = (int'(c) > 10) ? 10 : int'(c);
    r.d = 10'((dv * (1 << s)) % 1024);
    r.z = (s == 10);
    r.m = r.z ? 4'd0 : 4'(9 - s);
    if (dv == 0)      r.e = 1'b0;
    else if (s == 10) r.e = 1'b1;
    else              r.e = (((dv >> (9 - s)) % 2) == 0);
    r.cyc = 0;
    return r;
  endfunction

  function automatic logic [3:0] lzc(input logic [9:0] d);
    for (int i = 9; i >= 0; i--) if (d[i]) return 4'(9 - i);
    return 4'd10;
  endfunction

  // One clock: drive at negedge, observe just after, then record transfers.
  task automatic step(input logic iv, input logic [9:0] d, input logic [3:0] c, input logic ordy);
    exp_t h;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_cnt    = c;
    out_ready = ordy;
    #1;
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          h = q[0];
          check("out_data", 32'(out_data), 32'(h.d));
          check("out_msb_pos", 32'(out_msb_pos), 32'(h.m));
          check("out_zero", 32'(out_zero), 32'(h.z));
          check("out_err", 32'(out_err), 32'(h.e));
          if (out_ready) begin
            if (lat_mode) check("latency", 32'(cyc - h.cyc), 32'd2);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        h     = model(d, c);
        h.cyc = cyc;
        q.push_back(h);
        n_acc++;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 10'd0, 4'd0, 1'b1);
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  logic [9:0] d;
  int         acc0;

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 10'h155; in_cnt = 4'd1; out_ready = 1'b1;

    // Reset with input asserted.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_msb_pos", 32'(out_msb_pos), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Sweep of every shift amount, back-to-back.
    lat_mode = 1;
    for (int k = 0; k <= 10; k++) begin
      d = 10'h200 >> k;
      step(1'b1, d, 4'(k), 1'b1);
      check("sweep_in_ready", 32'(in_ready), 32'd1);
    end
    drain();
    lat_mode = 0;

    // Backpressure: only two words fit while the consumer stalls.
    acc0 = n_acc;
    for (int k = 0; k < 5; k++) begin
      d = 10'($urandom);
      step(1'b1, d, lzc(d), 1'b0);
    end
    check("stall_accepts", 32'(n_acc - acc0), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    drain();

    // Count inconsistent with data.
    step(1'b1, 10'h00F, 4'd3, 1'b1);
    step(1'b1, 10'h001, 4'd11, 1'b1);
    step(1'b1, 10'h000, 4'd15, 1'b1);
    drain();

    // Reset while the pipe is full and stalled.
    for (int k = 0; k < 3; k++) step(1'b1, 10'h0F0, 4'd2, 1'b0);
    rst = 1'b1;
    step(1'b1, 10'h0F0, 4'd2, 1'b0);
    rst = 1'b0;
    q.delete();
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);

    // Random traffic with consistent counts.
    for (int k = 0; k < 400; k++) begin
      d = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom >> $urandom_range(0, 9));
      step($urandom_range(0, 3) != 0, d, lzc(d), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
